// File: rtl/io_slot_pkg.sv
// -----------------------------------------------------------------------------
// io_slot_pkg
// Shared constants and helpers for the io_slot_sequencer block.
//   DEF_SLOTS / DEF_PIN_W / DEF_OUT_W : default frame geometry
//   FRAME_CNT_W                       : width of the optional frame counter
//   clog2()                           : constant-evaluable ceil(log2(value))
// No ports (package).
// -----------------------------------------------------------------------------
package io_slot_pkg;

    localparam int DEF_SLOTS   = 10;
    localparam int DEF_PIN_W   = 6;
    localparam int DEF_OUT_W   = 8;
    localparam int FRAME_CNT_W = 8;

    // ceil(log2(value)); clog2(SLOTS+1) gives enough bits to hold 0..SLOTS.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/io_slot_sequencer_if.sv
// -----------------------------------------------------------------------------
// io_slot_sequencer_if
// Bundles the core-facing and pin-facing signals of the slot sequencer.
//   sync        : synchronous resync request (parks the slot counter)
//   n_slots     : requested active slots per frame (sampled at slot-0 entry)
//   pins_in     : time-multiplexed input pin group
//   out_word    : next output frame from the core, slot k at [k*OUT_W +: OUT_W]
//   pins_out    : time-multiplexed output pin group
//   slot_oh     : one-hot current slot
//   in_frame    : last fully assembled input frame, slot k at [k*PIN_W +: PIN_W]
//   frame_valid : one-cycle pulse, in_frame updated and out_word consumed
// Modports: master (core / driver side), slave (the sequencer).
// -----------------------------------------------------------------------------
interface io_slot_sequencer_if
    import io_slot_pkg::*;
#(
    parameter int SLOTS = DEF_SLOTS,
    parameter int PIN_W = DEF_PIN_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter int NW    = clog2(SLOTS + 1)
);

    logic                   sync;
    logic [NW-1:0]          n_slots;
    logic [PIN_W-1:0]       pins_in;
    logic [SLOTS*OUT_W-1:0] out_word;
    logic [OUT_W-1:0]       pins_out;
    logic [SLOTS-1:0]       slot_oh;
    logic [SLOTS*PIN_W-1:0] in_frame;
    logic                   frame_valid;

    modport master (
        output sync, n_slots, pins_in, out_word,
        input  pins_out, slot_oh, in_frame, frame_valid
    );

    modport slave (
        input  sync, n_slots, pins_in, out_word,
        output pins_out, slot_oh, in_frame, frame_valid
    );

endinterface

// File: rtl/io_slot_sequencer_slot_ring.sv
// -----------------------------------------------------------------------------
// slot_ring
// One-hot slot ring counter with a park position and a per-frame latched
// active-slot count. All state changes on the falling edge of clk.
//   clk, reset_n  : clock (falling-edge active), async active-low reset
//   sync_i        : park the ring at the next edge
//   n_slots_i     : requested active count, latched only when slot 0 is entered
//   slot_oh_o     : registered one-hot slot
//   n_active_o    : latched active count N (1..SLOTS)
//   parked_o      : ring sits in park after reset/sync; not a real active slot
//   last_o        : the current slot is N-1 (combinational from registers)
// -----------------------------------------------------------------------------
module slot_ring
    import io_slot_pkg::*;
#(
    parameter int SLOTS = DEF_SLOTS,
    parameter int NW    = clog2(SLOTS + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sync_i,
    input  logic [NW-1:0]    n_slots_i,
    output logic [SLOTS-1:0] slot_oh_o,
    output logic [NW-1:0]    n_active_o,
    output logic             parked_o,
    output logic             last_o
);

    localparam logic [SLOTS-1:0] PARK_OH  = {1'b1, {(SLOTS-1){1'b0}}};
    localparam logic [SLOTS-1:0] SLOT0_OH = {{(SLOTS-1){1'b0}}, 1'b1};

    logic [SLOTS-1:0] slot_oh_q, slot_oh_d;
    logic [NW-1:0]    n_q, n_d;
    logic             parked_q, parked_d;
    logic [SLOTS-1:0] last_vec;
    logic [NW-1:0]    n_sel;
    logic             wrap;

    // last_vec[gi] marks "slot gi is active and gi == N-1".
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_last
        assign last_vec[gi] = slot_oh_q[gi] & (n_q == NW'(gi + 1));
    end

    assign last_o = |last_vec;

    // Out-of-range requests fall back to a full frame.
    assign n_sel = ((n_slots_i == '0) || (n_slots_i > NW'(SLOTS))) ? NW'(SLOTS) : n_slots_i;

    // Leaving park always goes to slot 0; with N == SLOTS park is also the last slot.
    assign wrap = slot_oh_q[SLOTS-1] | last_o;

    always_comb begin
        slot_oh_d = slot_oh_q;
        n_d       = n_q;
        parked_d  = parked_q;
        if (sync_i) begin
            slot_oh_d = PARK_OH;
            parked_d  = 1'b1;
        end else begin
            parked_d = 1'b0;
            if (wrap) begin
                slot_oh_d = SLOT0_OH;
                n_d       = n_sel;
            end else begin
                slot_oh_d = slot_oh_q << 1;
            end
        end
    end

    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_oh_q <= PARK_OH;
            n_q       <= NW'(SLOTS);
            parked_q  <= 1'b1;
        end else begin
            slot_oh_q <= slot_oh_d;
            n_q       <= n_d;
            parked_q  <= parked_d;
        end
    end

    assign slot_oh_o  = slot_oh_q;
    assign n_active_o = n_q;
    assign parked_o   = parked_q;

endmodule

// File: rtl/io_slot_sequencer.sv
// -----------------------------------------------------------------------------
// io_slot_sequencer
// Time-slot pin multiplexer: walks a one-hot slot ring, captures the input pin
// group into a per-slot buffer, publishes a completed input frame at the last
// active slot, and drives the output pin group from the frame latched at the
// previous frame boundary. State updates on the falling edge of clk.
//   clk         : clock (falling edge active)
//   reset_n     : asynchronous active-low reset
//   bus         : io_slot_sequencer_if.slave (sync, n_slots, pins_in, out_word,
//                 pins_out, slot_oh, in_frame, frame_valid)
//   frame_count : 8-bit completed-frame counter, present only when the macro
//                 IO_SLOT_FRAME_COUNT_EN is defined
// -----------------------------------------------------------------------------
module io_slot_sequencer
    import io_slot_pkg::*;
#(
    parameter int SLOTS = DEF_SLOTS,
    parameter int PIN_W = DEF_PIN_W,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic                   clk,
    input  logic                   reset_n,
    io_slot_sequencer_if.slave     bus
`ifdef IO_SLOT_FRAME_COUNT_EN
    ,
    output logic [FRAME_CNT_W-1:0] frame_count
`endif
);

    localparam int NW = clog2(SLOTS + 1);

    logic [SLOTS-1:0]       slot_oh;
    logic [NW-1:0]          n_active;
    logic                   parked;
    logic                   last_slot;
    logic                   step_en;
    logic                   frame_done;

    logic [SLOTS*PIN_W-1:0] buf_q, buf_d;
    logic [SLOTS*PIN_W-1:0] in_frame_q, in_frame_d;
    logic [SLOTS*OUT_W-1:0] out_frame_q;
    logic                   frame_valid_q;

    logic [SLOTS-1:0]       lane_live;
    logic [SLOTS-1:0]       cap_en;
    logic [SLOTS-1:0]       drive_en;
    logic [OUT_W-1:0]       lane_out [SLOTS];
    logic [OUT_W-1:0]       pins_out_c;

    slot_ring #(
        .SLOTS (SLOTS),
        .NW    (NW)
    ) u_ring (
        .clk        (clk),
        .reset_n    (reset_n),
        .sync_i     (bus.sync),
        .n_slots_i  (bus.n_slots),
        .slot_oh_o  (slot_oh),
        .n_active_o (n_active),
        .parked_o   (parked),
        .last_o     (last_slot)
    );

    // Park after reset/sync is idle time: nothing is captured or completed there,
    // and a sync request overrides whatever the current slot would have done.
    assign step_en    = ~parked & ~bus.sync;
    assign frame_done = step_en & last_slot;

    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_lane
        assign lane_live[gi] = (NW'(gi) < n_active);
        assign cap_en[gi]    = slot_oh[gi] & lane_live[gi] & step_en;
        assign drive_en[gi]  = slot_oh[gi] & lane_live[gi] & ~parked;
        // The completing slot's lane comes straight from the pins; lanes past N are zero.
        assign in_frame_d[gi*PIN_W +: PIN_W] = !lane_live[gi] ? '0 :
                                               slot_oh[gi]    ? bus.pins_in :
                                                                buf_q[gi*PIN_W +: PIN_W];
        assign lane_out[gi]  = drive_en[gi] ? out_frame_q[gi*OUT_W +: OUT_W] : '0;
    end

    always_comb begin
        buf_d = buf_q;
        for (int k = 0; k < SLOTS; k++) begin
            if (cap_en[k]) begin
                buf_d[k*PIN_W +: PIN_W] = bus.pins_in;
            end
        end
    end

    // Output lane mux: depends only on registered state, never on pins_in.
    always_comb begin
        pins_out_c = '0;
        for (int k = 0; k < SLOTS; k++) begin
            pins_out_c = pins_out_c | lane_out[k];
        end
    end

    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_q         <= '0;
            in_frame_q    <= '0;
            out_frame_q   <= '0;
            frame_valid_q <= 1'b0;
        end else begin
            buf_q         <= buf_d;
            frame_valid_q <= frame_done;
            if (frame_done) begin
                in_frame_q  <= in_frame_d;
                out_frame_q <= bus.out_word;
            end
        end
    end

`ifdef IO_SLOT_FRAME_COUNT_EN
    logic [FRAME_CNT_W-1:0] frame_count_q;

    // Counts completed frames; wraps naturally and ignores sync.
    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_count_q <= '0;
        end else if (frame_done) begin
            frame_count_q <= frame_count_q + 1'b1;
        end
    end

    assign frame_count = frame_count_q;
`endif

    assign bus.slot_oh     = slot_oh;
    assign bus.in_frame    = in_frame_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.pins_out    = pins_out_c;

endmodule

// File: tb/tb_io_slot_sequencer.sv
// -----------------------------------------------------------------------------
// tb_io_slot_sequencer
// Self-checking bench for io_slot_sequencer (SLOTS=10, PIN_W=6, OUT_W=8).
// Directed table, hand-written corner sequences and randomized traffic, all
// compared against a slot-index/array reference model. Inputs are driven at
// the rising edge, the DUT updates on the falling edge, outputs are sampled at
// the following rising edge. frame_count checks need IO_SLOT_FRAME_COUNT_EN.
// -----------------------------------------------------------------------------
module tb_io_slot_sequencer;
    import io_slot_pkg::*;

    localparam int S  = 10;
    localparam int PW = 6;
    localparam int OW = 8;
    localparam int NB = 4;

    logic clk;
    logic reset_n;

    io_slot_sequencer_if #(.SLOTS(S), .PIN_W(PW), .OUT_W(OW)) bus ();

`ifdef IO_SLOT_FRAME_COUNT_EN
    logic [FRAME_CNT_W-1:0] frame_count;
`endif

    io_slot_sequencer #(.SLOTS(S), .PIN_W(PW), .OUT_W(OW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus)
`ifdef IO_SLOT_FRAME_COUNT_EN
        ,
        .frame_count (frame_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // ---------------- reference model ----------------
    int          m_slot;        // current slot index (S-1 while parked)
    bit          m_idle;        // parked after reset/sync: no active slot
    int          m_n;           // latched active count
    bit          m_fv;
    int          m_fc;
    int          frames_seen;
    logic [PW-1:0] m_buf [S];
    logic [PW-1:0] m_in  [S];
    logic [OW-1:0] m_out [S];

    task automatic model_reset();
        m_slot = S - 1;
        m_idle = 1'b1;
        m_n    = S;
        m_fv   = 1'b0;
        m_fc   = 0;
        for (int k = 0; k < S; k++) begin
            m_buf[k] = '0;
            m_in[k]  = '0;
            m_out[k] = '0;
        end
    endtask

    task automatic model_step(input logic s, input logic [NB-1:0] n,
                              input logic [PW-1:0] p, input logic [S*OW-1:0] ow);
        m_fv = 1'b0;
        if (s) begin
            m_slot = S - 1;
            m_idle = 1'b1;
            return;
        end
        if (!m_idle && m_slot < m_n) begin
            m_buf[m_slot] = p;
            if (m_slot == m_n - 1) begin
                for (int k = 0; k < S; k++) begin
                    m_in[k]  = (k < m_n) ? m_buf[k] : '0;
                    m_out[k] = ow[k*OW +: OW];
                end
                m_fv = 1'b1;
                m_fc = (m_fc + 1) % 256;
                frames_seen++;
            end
        end
        if (m_slot == S - 1 || m_slot == m_n - 1) begin
            m_slot = 0;
            m_n    = (n == 0 || int'(n) > S) ? S : int'(n);
        end else begin
            m_slot++;
        end
        m_idle = 1'b0;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_model();
        logic [S*PW-1:0] exp_if;
        logic [OW-1:0]   exp_po;
        logic [S-1:0]    exp_oh;
        exp_oh = '0;
        exp_oh[m_slot] = 1'b1;
        for (int k = 0; k < S; k++) exp_if[k*PW +: PW] = m_in[k];
        exp_po = (!m_idle && m_slot < m_n) ? m_out[m_slot] : '0;
        check("model_slot_oh",     128'(bus.slot_oh),     128'(exp_oh));
        check("model_frame_valid", 128'(bus.frame_valid), 128'(m_fv));
        check("model_pins_out",    128'(bus.pins_out),    128'(exp_po));
        check("model_in_frame",    128'(bus.in_frame),    128'(exp_if));
`ifdef IO_SLOT_FRAME_COUNT_EN
        check("model_frame_count", 128'(frame_count),     128'(m_fc[7:0]));
`endif
    endtask

    // One clock: drive at the rising edge, DUT updates on the falling edge,
    // compare at the next rising edge.
    task automatic tick(input logic s, input logic [NB-1:0] n,
                        input logic [PW-1:0] p, input logic [S*OW-1:0] ow);
        bus.sync     = s;
        bus.n_slots  = n;
        bus.pins_in  = p;
        bus.out_word = ow;
        @(negedge clk);
        model_step(s, n, p, ow);
        @(posedge clk);
        check_model();
        if (m_fv) $display("frame %0d complete: in_frame=%h", frames_seen, bus.in_frame);
    endtask

    // Called at a rising edge; asserts reset between edges and releases it at the next rising edge.
    task automatic async_reset();
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check("rst_slot_oh",     128'(bus.slot_oh),     128'(10'h200));
        check("rst_frame_valid", 128'(bus.frame_valid), 128'(0));
        check("rst_pins_out",    128'(bus.pins_out),    128'(0));
        check("rst_in_frame",    128'(bus.in_frame),    128'(0));
`ifdef IO_SLOT_FRAME_COUNT_EN
        check("rst_frame_count", 128'(frame_count),     128'(0));
`endif
        @(posedge clk);
        reset_n = 1'b1;
    endtask

    logic [S*OW-1:0] ow_a;

    task automatic run_to_slot(input int target, input logic [NB-1:0] n);
        int guard;
        logic [S-1:0] one;
        one   = 1;
        guard = 0;
        while (bus.slot_oh !== (one << target) && guard < 30) begin
            tick(1'b0, n, PW'(6'h30 + m_slot), ow_a);
            guard++;
        end
        check($sformatf("reach_slot%0d", target), 128'(bus.slot_oh), 128'(one << target));
    endtask

    typedef struct {
        logic          sync_v;
        logic [NB-1:0] n_v;
        logic [PW-1:0] pin_v;
        logic [S-1:0]  exp_oh;
        logic          exp_fv;
        logic [OW-1:0] exp_po;
    } vec_t;

    vec_t vt [22];

    logic [S*PW-1:0] exp_k;
    logic [S*PW-1:0] exp_e4;
    logic [S-1:0]    seq_oh [8];
    logic            seq_fv [8];
    logic [S*OW-1:0] ow_r;
    logic            s_r;
    logic [NB-1:0]   n_r;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // ---- stimulus tables ----
        for (int k = 0; k < S; k++) ow_a[k*OW +: OW] = OW'(8'hA0 + k);
        for (int i = 0; i < 22; i++) begin
            vt[i].sync_v = 1'b0;
            vt[i].n_v    = 4'd10;
            vt[i].pin_v  = (i == 0) ? 6'd0 : PW'((i - 1) % 10);
            vt[i].exp_oh = (i == 0) ? 10'h200 : (10'h001 << ((i - 1) % 10));
            vt[i].exp_fv = (i == 11 || i == 21);
            vt[i].exp_po = (i >= 11) ? OW'(8'hA0 + (i - 1) % 10) : 8'h00;
        end
        exp_k  = '0;
        exp_e4 = '0;
        for (int k = 0; k < S; k++) exp_k[k*PW +: PW] = PW'(k);
        for (int k = 0; k < 4; k++) exp_e4[k*PW +: PW] = PW'(6'h30 + k);
        seq_oh = '{10'h080, 10'h100, 10'h200, 10'h001, 10'h002, 10'h004, 10'h008, 10'h001};
        seq_fv = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

        reset_n      = 1'b1;
        bus.sync     = 1'b0;
        bus.n_slots  = 4'd10;
        bus.pins_in  = '0;
        bus.out_word = '0;
        frames_seen  = 0;
        model_reset();

        @(posedge clk);
        async_reset();

        // ---- reset release, rotation, capture and output lanes ----
        for (int i = 0; i < 22; i++) begin
            check($sformatf("tbl%0d_slot_oh", i),  128'(bus.slot_oh),     128'(vt[i].exp_oh));
            check($sformatf("tbl%0d_fv", i),       128'(bus.frame_valid), 128'(vt[i].exp_fv));
            check($sformatf("tbl%0d_pins_out", i), 128'(bus.pins_out),    128'(vt[i].exp_po));
            tick(vt[i].sync_v, vt[i].n_v, vt[i].pin_v, ow_a);
        end
        check("tbl_in_frame_lanes", 128'(bus.in_frame), 128'(exp_k));

        // ---- n_slots=4 written during slot 6: takes effect at next slot 0 ----
        run_to_slot(6, 4'd10);
        for (int j = 0; j < 8; j++) begin
            tick(1'b0, 4'd4, PW'(6'h30 + m_slot), ow_a);
            check($sformatf("n4_seq%0d_slot_oh", j), 128'(bus.slot_oh),     128'(seq_oh[j]));
            check($sformatf("n4_seq%0d_fv", j),      128'(bus.frame_valid), 128'(seq_fv[j]));
        end
        check("n4_in_frame_zero_lanes", 128'(bus.in_frame), 128'(exp_e4));
        tick(1'b1, 4'd4, 6'h3f, ow_a);
        check("n4_park_slot_oh",  128'(bus.slot_oh),  128'(10'h200));
        check("n4_park_pins_out", 128'(bus.pins_out), 128'(0));
        tick(1'b0, 4'd4, 6'h30, ow_a);
        check("n4_unpark_slot_oh", 128'(bus.slot_oh), 128'(10'h001));

        // ---- back to N=10, then sync during slot 5 ----
        run_to_slot(3, 4'd10);
        tick(1'b0, 4'd10, 6'h33, ow_a);
        check("n10_relatch_slot_oh", 128'(bus.slot_oh), 128'(10'h001));
        run_to_slot(5, 4'd10);
        tick(1'b1, 4'd10, 6'h35, ow_a);
        check("sync5_park",     128'(bus.slot_oh),     128'(10'h200));
        check("sync5_no_fv",    128'(bus.frame_valid), 128'(0));
        tick(1'b0, 4'd10, 6'h39, ow_a);
        check("sync5_slot0",    128'(bus.slot_oh),     128'(10'h001));
        check("sync5_no_fv2",   128'(bus.frame_valid), 128'(0));
        check("sync5_in_frame", 128'(bus.in_frame),    128'(exp_e4));

        // ---- sync on the last active slot: no frame completes ----
        run_to_slot(9, 4'd10);
        tick(1'b1, 4'd10, 6'h39, ow_a);
        check("sync9_no_fv",    128'(bus.frame_valid), 128'(0));
        check("sync9_in_frame", 128'(bus.in_frame),    128'(exp_e4));
        tick(1'b0, 4'd10, 6'h00, ow_a);
        check("sync9_slot0",    128'(bus.slot_oh),     128'(10'h001));
        check("sync9_no_fv2",   128'(bus.frame_valid), 128'(0));

        // ---- randomized traffic with occasional mid-frame resets ----
        n_r = 4'd10;
        for (int i = 0; i < 600; i++) begin
            if (i == 200 || i == 400) async_reset();
            s_r  = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 9) == 0) n_r = NB'($urandom_range(0, 15));
            ow_r = {$urandom, $urandom, $urandom};
            tick(s_r, n_r, PW'($urandom), ow_r);
        end

`ifdef IO_SLOT_FRAME_COUNT_EN
        // ---- frame counter wraps after 256 frames ----
        async_reset();
        frames_seen = 0;
        for (int g = 0; g < 800 && frames_seen < 257; g++) begin
            tick(1'b0, 4'd2, PW'($urandom), ow_a);
        end
        check("fc_after_257", 128'(frame_count), 128'(1));
        tick(1'b0, 4'd2, 6'h11, ow_a);
        async_reset();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/io_slot_sequencer.md
IO_SLOT_SEQUENCER -- requirements
Module: io_slot_sequencer

Interface
REQ-001 Parameter SLOTS, default 10, number of time slots per frame (2..16).
REQ-002 Parameter PIN_W, default 6, input pin-group width captured per slot.
REQ-003 Parameter OUT_W, default 8, output pin-group width driven per slot.
REQ-004 Port clk  in  1  single clock; all state updates on falling edge.
REQ-005 Port reset_n  in  1  asynchronous, active-low reset.
REQ-006 Port sync  in  1  synchronous resync: park slot counter, data registers untouched.
REQ-007 Port n_slots  in  clog2(SLOTS+1)  active slots per frame; sampled at frame boundary only.
REQ-008 Port pins_in  in  PIN_W  time-multiplexed input group.
REQ-009 Port pins_out  out  OUT_W  time-multiplexed output group.
REQ-010 Port slot_oh  out  SLOTS  one-hot current slot.
REQ-011 Port in_frame  out  SLOTS*PIN_W  last fully assembled input frame; slot k at bits [k*PIN_W +: PIN_W].
REQ-012 Port frame_valid  out  1  one-cycle pulse: in_frame updated and out_word consumed.
REQ-013 Port out_word  in  SLOTS*OUT_W  next output frame from core; slot k at bits [k*OUT_W +: OUT_W].

Function
REQ-014 Park slot = bit SLOTS-1; from park, next slot is 0 unconditionally.
REQ-015 Rotation: slot k advances to k+1; slot N-1 (N = latched active count) wraps to 0.
REQ-016 With N = SLOTS, sequence is pure rotate-left of slot_oh; park coincides with last slot.
REQ-017 Latched N updates from n_slots only on the edge where slot 0 is entered; n_slots = 0 or > SLOTS -> N = SLOTS.
REQ-018 Slot k < N active: pins_in captured into shift buffer lane k at that falling edge.
REQ-019 Slot N-1 active: at same edge, in_frame <= buffer with lane N-1 replaced by current pins_in; lanes >= N zeroed.
REQ-020 Same edge: out_frame <= out_word; frame_valid = 1 for following cycle exactly.
REQ-021 pins_out = out_frame lane k while slot k < N active; 0 when active slot >= N (incl. park with N < SLOTS).
REQ-022 pins_out combinational from registered slot_oh and out_frame only; no pins_in to pins_out path.
REQ-023 sync = 1: slot_oh <= park at next edge; no capture, no frame_valid; partial frame discarded.
REQ-024 sync held: counter remains parked; release -> slot 0 on next edge; N re-latched there.
REQ-025 sync asserted while slot N-1 active: sync wins, no frame completes.
REQ-026 n_slots change mid-frame: no effect until next slot-0 entry.

Reset
REQ-027 reset_n low: slot_oh = park, latched N = SLOTS, shift buffer, in_frame, out_frame = 0, frame_valid = 0, pins_out = 0.
REQ-028 Reset assertion asynchronous; deassertion takes effect at next falling edge; first active slot is 0.
REQ-029 Reset mid-frame: partial frame discarded, no frame_valid pulse.

Configuration
REQ-030 Macro IO_SLOT_FRAME_COUNT_EN defined: extra output frame_count, 8 bits, reset 0, increments on each frame_valid, wraps 255 -> 0, unaffected by sync.
REQ-031 Macro undefined: frame_count port and counter absent; all other behaviour identical.

Structure
REQ-032 Package io_slot_pkg: default SLOTS/PIN_W/OUT_W constants, clog2 helper, frame-count width constant.
REQ-033 Sub-module slot_ring: one-hot ring counter with park, sync, latched N; instanced once.
REQ-034 Capture, assembly, output lane mux in top module.

Verification (SLOTS=10, PIN_W=6, OUT_W=8)
REQ-035 Reset release, n_slots=10 -> slot_oh 0x200 then 0x001,0x002,...,0x200,0x001; frame_valid every 10th cycle.
REQ-036 pins_in = slot index k (0..9) over one frame -> in_frame lane k = k, frame_valid one cycle after slot 9.
REQ-037 out_word lanes = 0xA0+k, latched at slot 9 -> next frame pins_out = 0xA0..0xA9 in slots 0..9.
REQ-038 n_slots=4 written during slot 6 -> current frame runs to slot 9; next frame wraps 3->0; in_frame lanes 4..9 = 0; pins_out 0 when parked.
REQ-039 sync pulse during slot 5 -> park next cycle, then slot 0; no frame_valid for aborted frame; in_frame keeps prior value.
REQ-040 IO_SLOT_FRAME_COUNT_EN, 257 frames with n_slots=2 -> frame_count = 1; reset_n low mid-frame -> 0 immediately.
